// File: rtl/mux2x1_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux2x1_arbiter_if
// Bundles the two requester channels (A, B), the shared output channel (D) and
// the mux select of the 2x1 datapath arbiter.
//
// Signals
//   a_valid / a_data / a_ready : requester A handshake
//   b_valid / b_data / b_ready : requester B handshake
//   d_valid / d_data / d_ready : output register handshake to the consumer
//   sel                        : last granted source (0 = A, 1 = B)
//
// Modports
//   master : the arbiter itself, which owns the output channel and drives the
//            readies, the output register and the select
//   slave  : the surrounding producers/consumer
// -----------------------------------------------------------------------------
interface mux2x1_arbiter_if #(
   parameter int DATAWIDTH = 16
);
   logic                 a_valid;
   logic [DATAWIDTH-1:0] a_data;
   logic                 a_ready;
   logic                 b_valid;
   logic [DATAWIDTH-1:0] b_data;
   logic                 b_ready;
   logic                 d_valid;
   logic [DATAWIDTH-1:0] d_data;
   logic                 d_ready;
   logic                 sel;

   modport master (
      input  a_valid, a_data, b_valid, b_data, d_ready,
      output a_ready, b_ready, d_valid, d_data, sel
   );

   modport slave (
      output a_valid, a_data, b_valid, b_data, d_ready,
      input  a_ready, b_ready, d_valid, d_data, sel
   );
endinterface

// File: rtl/mux2x1_arbiter.sv
// -----------------------------------------------------------------------------
// mux2x1_arbiter
// Round-robin arbiter and sequencer for the 2x1 datapath multiplexer. Two
// valid/ready requesters share one output register. The current owner may keep
// the channel for up to BURST consecutive beats while the other side waits;
// otherwise ties go to the side that did not win last.
//
// Parameters
//   DATAWIDTH : width of a_data, b_data and d_data
//   BURST     : max consecutive beats for one side under contention (>= 1)
//
// Ports
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : mux2x1_arbiter_if.master (requesters A/B, output channel D, sel)
//
// a_ready/b_ready are combinational (depend on d_ready, the valids, state,
// sel and burst_cnt). d_valid, d_data and sel are registered.
// -----------------------------------------------------------------------------
module mux2x1_arbiter #(
   parameter int DATAWIDTH = 16,
   parameter int BURST     = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   mux2x1_arbiter_if.master        bus
);

   // Counter holds 0..BURST; guard keeps the width sane for a bad BURST < 1.
   localparam int CW = (BURST < 1) ? 1 : $clog2(BURST + 1);
   localparam logic [CW-1:0] BURST_MAX = CW'(BURST);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } state_t;

   state_t               state_r;
   state_t               state_s;
   logic [CW-1:0]        burst_cnt_r;
   logic [CW-1:0]        burst_cnt_s;
   logic                 d_valid_r;
   logic                 d_valid_s;
   logic [DATAWIDTH-1:0] d_data_r;
   logic [DATAWIDTH-1:0] d_data_s;
   logic                 sel_r;
   logic                 sel_s;

   logic                 load_s;
   logic                 keep_s;
   logic                 grant_s;
   logic                 grant_b_s;
   logic                 same_owner_s;
   logic                 a_ready_s;
   logic                 b_ready_s;

   // Saturating increment of the burst counter.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
      logic [CW-1:0] res;
      if (cnt >= BURST_MAX) begin
         res = cnt;
      end else begin
         res = cnt + CW'(1);
      end
      return res;
   endfunction

   // The output register can accept a beat when empty or being drained.
   assign load_s = ~d_valid_r | bus.d_ready;

   // Grant selection: owner keeps the burst unless it dropped valid or hit the
   // limit while the other side waits; otherwise round-robin on sel.
   always_comb begin
      keep_s    = 1'b0;
      grant_s   = 1'b0;
      grant_b_s = 1'b0;
      case (state_r)
         OWN_A: begin
            if (bus.a_valid && ((burst_cnt_r < BURST_MAX) || !bus.b_valid)) begin
               keep_s = 1'b1;
            end else begin
               keep_s = 1'b0;
            end
         end
         OWN_B: begin
            if (bus.b_valid && ((burst_cnt_r < BURST_MAX) || !bus.a_valid)) begin
               keep_s = 1'b1;
            end else begin
               keep_s = 1'b0;
            end
         end
         default: begin
            keep_s = 1'b0;
         end
      endcase

      if (keep_s) begin
         grant_s   = 1'b1;
         grant_b_s = (state_r == OWN_B);
      end else if (bus.a_valid && bus.b_valid) begin
         // Tie: the side that did not win last goes next.
         grant_s   = 1'b1;
         grant_b_s = ~sel_r;
      end else if (bus.a_valid) begin
         grant_s   = 1'b1;
         grant_b_s = 1'b0;
      end else if (bus.b_valid) begin
         grant_s   = 1'b1;
         grant_b_s = 1'b1;
      end else begin
         grant_s   = 1'b0;
         grant_b_s = 1'b0;
      end
   end

   // Ready goes only to the granted side, and never while reset is asserted.
   always_comb begin
      a_ready_s = ~rst & load_s & grant_s & ~grant_b_s;
      b_ready_s = ~rst & load_s & grant_s &  grant_b_s;
   end

   // Next-state / datapath: load the granted beat, drop to IDLE on an empty
   // load slot, hold everything under backpressure.
   always_comb begin
      state_s      = state_r;
      burst_cnt_s  = burst_cnt_r;
      d_valid_s    = d_valid_r;
      d_data_s     = d_data_r;
      sel_s        = sel_r;
      same_owner_s = grant_b_s ? (state_r == OWN_B) : (state_r == OWN_A);

      if (load_s) begin
         if (grant_s) begin
            // grant implies the granted side is valid, so this is a transfer.
            d_data_s  = grant_b_s ? bus.b_data : bus.a_data;
            d_valid_s = 1'b1;
            sel_s     = grant_b_s;
            state_s   = grant_b_s ? OWN_B : OWN_A;
            if (same_owner_s) begin
               burst_cnt_s = sat_inc(burst_cnt_r);
            end else begin
               burst_cnt_s = CW'(1);
            end
         end else begin
            d_valid_s   = 1'b0;
            state_s     = IDLE;
            burst_cnt_s = {CW{1'b0}};
         end
      end else begin
         state_s     = state_r;
         burst_cnt_s = burst_cnt_r;
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         burst_cnt_r <= {CW{1'b0}};
         d_valid_r   <= 1'b0;
         d_data_r    <= {DATAWIDTH{1'b0}};
         sel_r       <= 1'b1;
      end else begin
         state_r     <= state_s;
         burst_cnt_r <= burst_cnt_s;
         d_valid_r   <= d_valid_s;
         d_data_r    <= d_data_s;
         sel_r       <= sel_s;
      end
   end

   assign bus.a_ready = a_ready_s;
   assign bus.b_ready = b_ready_s;
   assign bus.d_valid = d_valid_r;
   assign bus.d_data  = d_data_r;
   assign bus.sel     = sel_r;

endmodule

// File: tb/tb_mux2x1_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux2x1_arbiter
// Self-checking bench: directed scenarios plus randomized traffic, all compared
// against a behavioural model of the arbitration rules (owner / run length /
// last winner) and of the one-entry output register.
// -----------------------------------------------------------------------------
module tb_mux2x1_arbiter;

   localparam int DW    = 16;
   localparam int BURST = 4;

   logic clk;
   logic rst;

   mux2x1_arbiter_if #(.DATAWIDTH(DW)) bus ();

   mux2x1_arbiter #(.DATAWIDTH(DW), .BURST(BURST)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model: owner -1 = none, 0 = A, 1 = B.
   int          m_owner;
   int          m_run;
   int          m_last;
   logic        m_dv;
   logic [DW-1:0] m_dd;
   logic        m_took_a;
   logic        m_took_b;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_run   = 0;
      m_last  = 1;
      m_dv    = 1'b0;
      m_dd    = '0;
   endtask

   function automatic int model_grant(input logic av, input logic bv);
      int g;
      if (m_owner == 0 && av && (m_run < BURST || !bv))      g = 0;
      else if (m_owner == 1 && bv && (m_run < BURST || !av)) g = 1;
      else if (av && bv)                                     g = 1 - m_last;
      else if (av)                                           g = 0;
      else if (bv)                                           g = 1;
      else                                                   g = -1;
      return g;
   endfunction

   // Called right after a negedge with inputs already driven: checks readies,
   // advances one clock, updates the model and checks registered outputs.
   task automatic step_cycle();
      int          g;
      logic        ld;
      logic [DW-1:0] ad;
      logic [DW-1:0] bd;
      #1;
      g  = model_grant(bus.a_valid, bus.b_valid);
      ld = !m_dv || bus.d_ready;
      ad = bus.a_data;
      bd = bus.b_data;
      check_val("a_ready", 32'(bus.a_ready), 32'(ld && g == 0));
      check_val("b_ready", 32'(bus.b_ready), 32'(ld && g == 1));
      @(posedge clk);
      m_took_a = 1'b0;
      m_took_b = 1'b0;
      if (ld) begin
         if (g >= 0) begin
            m_dd  = (g == 1) ? bd : ad;
            m_dv  = 1'b1;
            m_run = (m_owner == g) ? ((m_run < BURST) ? m_run + 1 : BURST) : 1;
            m_owner = g;
            m_last  = g;
            if (g == 0) m_took_a = 1'b1;
            else        m_took_b = 1'b1;
         end else begin
            m_dv    = 1'b0;
            m_owner = -1;
            m_run   = 0;
         end
      end
      @(negedge clk);
      check_val("d_valid", 32'(bus.d_valid), 32'(m_dv));
      check_val("d_data",  32'(bus.d_data),  32'(m_dd));
      check_val("sel",     32'(bus.sel),     32'(m_last));
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   logic [DW-1:0] exp_seq [12];
   int a_cnt;
   int b_cnt;

   initial begin
      exp_seq = '{16'hA000, 16'hA001, 16'hA002, 16'hA003,
                  16'hB000, 16'hB001, 16'hB002, 16'hB003,
                  16'hA004, 16'hA005, 16'hA006, 16'hA007};
      model_reset();
      m_took_a = 1'b0;
      m_took_b = 1'b0;

      // Reset with both requesters active.
      rst         = 1'b1;
      bus.a_valid = 1'b1;
      bus.b_valid = 1'b1;
      bus.a_data  = 16'h1111;
      bus.b_data  = 16'h2222;
      bus.d_ready = 1'b1;
      #1;
      check_val("rst_a_ready", 32'(bus.a_ready), 32'd0);
      check_val("rst_b_ready", 32'(bus.b_ready), 32'd0);
      check_val("rst_d_valid", 32'(bus.d_valid), 32'd0);
      check_val("rst_d_data",  32'(bus.d_data),  32'd0);
      check_val("rst_sel",     32'(bus.sel),     32'd1);
      @(negedge clk);
      rst = 1'b0;
      // First tie after reset goes to A.
      step_cycle();
      check_val("first_tie_sel", 32'(bus.sel), 32'd0);

      // Single requester: six consecutive A beats.
      pulse_reset();
      bus.b_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.a_valid = 1'b1;
         bus.a_data  = 16'(i + 1);
         step_cycle();
         check_val("single_data", 32'(bus.d_data), 32'(i + 1));
         check_val("single_sel",  32'(bus.sel),    32'd0);
      end

      // Contention with BURST=4: A0..A3, B0..B3, A4..A7.
      pulse_reset();
      a_cnt = 0;
      b_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         bus.a_valid = 1'b1;
         bus.b_valid = 1'b1;
         bus.a_data  = 16'hA000 + 16'(a_cnt);
         bus.b_data  = 16'hB000 + 16'(b_cnt);
         bus.d_ready = 1'b1;
         step_cycle();
         check_val("contention_seq", 32'(bus.d_data), 32'(exp_seq[i]));
         if (m_took_a) a_cnt++;
         if (m_took_b) b_cnt++;
      end

      // Backpressure: hold 0x1234 for three stalled cycles.
      bus.b_valid = 1'b0;
      bus.a_valid = 1'b1;
      bus.a_data  = 16'h1234;
      bus.d_ready = 1'b1;
      step_cycle();
      bus.b_valid = 1'b1;
      bus.a_data  = 16'h9999;
      bus.b_data  = 16'h8888;
      bus.d_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step_cycle();
         check_val("bp_hold", 32'(bus.d_data), 32'h1234);
      end
      bus.d_ready = 1'b1;
      bus.b_valid = 1'b0;
      bus.a_data  = 16'h5678;
      step_cycle();
      check_val("bp_release", 32'(bus.d_data), 32'h5678);

      // Owner drops mid-burst: A takes 2, then only B is valid.
      pulse_reset();
      bus.a_valid = 1'b1;
      bus.b_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.a_data = 16'h0A00 + 16'(i);
         step_cycle();
      end
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b1;
      bus.b_data  = 16'h0B00;
      #1;
      check_val("drop_b_ready", 32'(bus.b_ready), 32'd1);
      step_cycle();
      check_val("drop_sel", 32'(bus.sel), 32'd1);
      // B restarted at 1, so it gets three more beats under contention.
      bus.a_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.b_data = 16'h0B01 + 16'(i);
         step_cycle();
         check_val("drop_run_sel", 32'(bus.sel), (i < 3) ? 32'd1 : 32'd0);
      end

      // Asynchronous reset between edges while d_valid=1.
      rst = 1'b1;
      #1;
      check_val("arst_d_valid", 32'(bus.d_valid), 32'd0);
      check_val("arst_d_data",  32'(bus.d_data),  32'd0);
      check_val("arst_sel",     32'(bus.sel),     32'd1);
      check_val("arst_a_ready", 32'(bus.a_ready), 32'd0);
      #1;
      rst = 1'b0;
      model_reset();
      bus.a_valid = 1'b1;
      bus.b_valid = 1'b1;
      bus.a_data  = 16'hC0DE;
      step_cycle();
      check_val("arst_resume", 32'(bus.d_data), 32'hC0DE);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         bus.a_valid = ($urandom_range(0, 3) != 0);
         bus.b_valid = ($urandom_range(0, 3) != 0);
         bus.a_data  = 16'($urandom);
         bus.b_data  = 16'($urandom);
         bus.d_ready = ($urandom_range(0, 3) != 0);
         step_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
